// File: rtl/gpu_mem_arbiter.sv
// Round-robin arbiter sharing one GPU memory port between the controller (port 0)
// and the core (port 1), with registered req/ack handshakes and an optional timeout.
module gpu_mem_arbiter #(
  parameter int addr_width     = 32,
  parameter int data_width     = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  // controller port (port 0)
  input  logic                  c_req,
  input  logic                  c_wr,
  input  logic [addr_width-1:0] c_addr,
  input  logic [data_width-1:0] c_wr_data,
  output logic                  c_ack,
  output logic                  c_err,
  output logic [data_width-1:0] c_rd_data,
  // core port (port 1)
  input  logic                  k_req,
  input  logic                  k_wr,
  input  logic [addr_width-1:0] k_addr,
  input  logic [data_width-1:0] k_wr_data,
  output logic                  k_ack,
  output logic                  k_err,
  output logic [data_width-1:0] k_rd_data,
  // memory side
  output logic                  mem_req,
  output logic                  mem_wr,
  output logic [addr_width-1:0] mem_addr,
  output logic [data_width-1:0] mem_wr_data,
  input  logic                  mem_ack,
  input  logic [data_width-1:0] mem_rd_data
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] TMO_LAST =
    (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t           state, state_next;
  logic             last_grant;
  logic [CNT_W-1:0] cnt;
  logic             grant_valid;
  logic             grant_port;
  logic             done;
  logic             tmo;

  // NOTE: every signal driven here gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next  = state;
    grant_valid = c_req | k_req;
    // Contention goes to the port that did not win last time; otherwise the lone requester.
    grant_port  = (c_req && k_req) ? ~last_grant : k_req;
    done        = (state == BUSY) && mem_ack;
    tmo         = (state == BUSY) && !mem_ack && (TIMEOUT_CYCLES != 0) && (cnt == TMO_LAST);
    case (state)
      IDLE:    if (grant_valid) state_next = BUSY;
      BUSY:    if (done || tmo) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from values sampled before the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant  <= 1'b1;
      cnt         <= '0;
      mem_req     <= 1'b0;
      mem_wr      <= 1'b0;
      mem_addr    <= '0;
      mem_wr_data <= '0;
      c_ack       <= 1'b0;
      c_err       <= 1'b0;
      c_rd_data   <= '0;
      k_ack       <= 1'b0;
      k_err       <= 1'b0;
      k_rd_data   <= '0;
    end else begin
      c_ack <= 1'b0;
      c_err <= 1'b0;
      k_ack <= 1'b0;
      k_err <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_valid) begin
            mem_req     <= 1'b1;
            mem_wr      <= grant_port ? k_wr      : c_wr;
            mem_addr    <= grant_port ? k_addr    : c_addr;
            mem_wr_data <= grant_port ? k_wr_data : c_wr_data;
            last_grant  <= grant_port;
            cnt         <= '0;
          end
        end
        BUSY: begin
          if (done || tmo) begin
            mem_req <= 1'b0;
            // last_grant names the current winner for the whole transaction.
            if (last_grant) begin
              k_ack     <= 1'b1;
              k_err     <= tmo;
              k_rd_data <= (done && !mem_wr) ? mem_rd_data : '0;
            end else begin
              c_ack     <= 1'b1;
              c_err     <= tmo;
              c_rd_data <= (done && !mem_wr) ? mem_rd_data : '0;
            end
          end else if (cnt != {CNT_W{1'b1}}) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gpu_mem_arbiter.sv
// Directed bench for gpu_mem_arbiter: one instance with the default timeout and
// one with TIMEOUT_CYCLES = 4, sharing requester stimulus but reset separately.
module tb_gpu_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst, rst_t;
  logic        c_req, c_wr, k_req, k_wr;
  logic [31:0] c_addr, c_wr_data, k_addr, k_wr_data;
  logic        mem_ack, mem_ack_t;
  logic [31:0] mem_rd_data;

  logic        c_ack, c_err, k_ack, k_err, mem_req, mem_wr;
  logic [31:0] c_rd_data, k_rd_data, mem_addr, mem_wr_data;
  logic        t_c_ack, t_c_err, t_k_ack, t_k_err, t_mem_req, t_mem_wr;
  logic [31:0] t_c_rd_data, t_k_rd_data, t_mem_addr, t_mem_wr_data;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  gpu_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_wr(c_wr), .c_addr(c_addr), .c_wr_data(c_wr_data),
    .c_ack(c_ack), .c_err(c_err), .c_rd_data(c_rd_data),
    .k_req(k_req), .k_wr(k_wr), .k_addr(k_addr), .k_wr_data(k_wr_data),
    .k_ack(k_ack), .k_err(k_err), .k_rd_data(k_rd_data),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
    .mem_ack(mem_ack), .mem_rd_data(mem_rd_data)
  );

  gpu_mem_arbiter #(.TIMEOUT_CYCLES(4)) dut_t (
    .clk(clk), .rst(rst_t),
    .c_req(c_req), .c_wr(c_wr), .c_addr(c_addr), .c_wr_data(c_wr_data),
    .c_ack(t_c_ack), .c_err(t_c_err), .c_rd_data(t_c_rd_data),
    .k_req(k_req), .k_wr(k_wr), .k_addr(k_addr), .k_wr_data(k_wr_data),
    .k_ack(t_k_ack), .k_err(t_k_err), .k_rd_data(t_k_rd_data),
    .mem_req(t_mem_req), .mem_wr(t_mem_wr), .mem_addr(t_mem_addr), .mem_wr_data(t_mem_wr_data),
    .mem_ack(mem_ack_t), .mem_rd_data(mem_rd_data)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock and sample just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; rst_t = 1'b1;
    c_req = 0; c_wr = 0; c_addr = 0; c_wr_data = 0;
    k_req = 0; k_wr = 0; k_addr = 0; k_wr_data = 0;
    mem_ack = 0; mem_ack_t = 0; mem_rd_data = 0;
    tick(); tick();
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_c_ack", {31'd0, c_ack}, 32'd0);
    check("rst_k_ack", {31'd0, k_ack}, 32'd0);
    check("rst_c_rd_data", c_rd_data, 32'd0);
    rst = 1'b0;

    // Controller read, memory acks in the first mem_req cycle.
    c_req = 1; c_wr = 0; c_addr = 32'h10;
    tick();
    check("t1_mem_req", {31'd0, mem_req}, 32'd1);
    check("t1_mem_addr", mem_addr, 32'h10);
    check("t1_mem_wr", {31'd0, mem_wr}, 32'd0);
    mem_ack = 1; mem_rd_data = 32'hDEADBEEF;
    tick();
    check("t1_c_ack", {31'd0, c_ack}, 32'd1);
    check("t1_c_err", {31'd0, c_err}, 32'd0);
    check("t1_c_rd_data", c_rd_data, 32'hDEADBEEF);
    check("t1_k_ack", {31'd0, k_ack}, 32'd0);
    check("t1_mem_req_drop", {31'd0, mem_req}, 32'd0);
    mem_ack = 0; c_req = 0;
    tick();
    check("t1_c_ack_pulse", {31'd0, c_ack}, 32'd0);
    tick();
    check("t1_idle_mem_req", {31'd0, mem_req}, 32'd0);

    // Core write, memory acks in the fifth BUSY cycle.
    mem_rd_data = 32'hCAFEF00D;
    k_req = 1; k_wr = 1; k_addr = 32'h20; k_wr_data = 32'h1234;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("t2_mem_req", {31'd0, mem_req}, 32'd1);
      check("t2_mem_wr", {31'd0, mem_wr}, 32'd1);
      check("t2_mem_addr", mem_addr, 32'h20);
      check("t2_mem_wr_data", mem_wr_data, 32'h1234);
      check("t2_k_ack_early", {31'd0, k_ack}, 32'd0);
      if (i == 4) mem_ack = 1;
      tick();
    end
    check("t2_k_ack", {31'd0, k_ack}, 32'd1);
    check("t2_k_err", {31'd0, k_err}, 32'd0);
    check("t2_k_rd_data", k_rd_data, 32'd0);
    check("t2_c_ack", {31'd0, c_ack}, 32'd0);
    check("t2_c_rd_hold", c_rd_data, 32'hDEADBEEF);
    mem_ack = 0; k_req = 0; k_wr = 0;
    tick();

    // Both ports requesting continuously: grants alternate 0,1,0,1.
    c_req = 1; c_wr = 0; c_addr = 32'h100;
    k_req = 1; k_wr = 0; k_addr = 32'h200;
    for (int i = 0; i < 4; i++) begin
      logic [31:0] exp_addr, exp_data;
      exp_addr = (i % 2 == 0) ? 32'h100 : 32'h200;
      exp_data = 32'hA0 + 32'(i);
      tick();
      check("t3_mem_req", {31'd0, mem_req}, 32'd1);
      check("t3_grant_addr", mem_addr, exp_addr);
      mem_ack = 1; mem_rd_data = exp_data;
      tick();
      check("t3_c_ack", {31'd0, c_ack}, (i % 2 == 0) ? 32'd1 : 32'd0);
      check("t3_k_ack", {31'd0, k_ack}, (i % 2 == 1) ? 32'd1 : 32'd0);
      check("t3_rd_data", (i % 2 == 0) ? c_rd_data : k_rd_data, exp_data);
      mem_ack = 0;
      tick();
      check("t3_c_ack_pulse", {31'd0, c_ack}, 32'd0);
      check("t3_k_ack_pulse", {31'd0, k_ack}, 32'd0);
    end
    c_req = 0; k_req = 0;
    tick();

    // Reset in the middle of a core transaction.
    k_req = 1;
    tick();
    check("t5_busy", {31'd0, mem_req}, 32'd1);
    c_req = 1;
    #3 rst = 1;
    #1;
    check("t5_async_mem_req", {31'd0, mem_req}, 32'd0);
    mem_ack = 1;
    tick();
    check("t5_no_c_ack", {31'd0, c_ack}, 32'd0);
    check("t5_no_k_ack", {31'd0, k_ack}, 32'd0);
    mem_ack = 0;
    tick();
    rst = 0;
    tick();
    check("t5_regrant", {31'd0, mem_req}, 32'd1);
    check("t5_port0_first", mem_addr, 32'h100);
    check("t5_k_ack_quiet", {31'd0, k_ack}, 32'd0);
    mem_ack = 1; mem_rd_data = 32'h77;
    tick();
    check("t5_c_ack", {31'd0, c_ack}, 32'd1);
    check("t5_k_ack", {31'd0, k_ack}, 32'd0);
    mem_ack = 0; c_req = 0; k_req = 0;
    tick();

    // Spurious mem_ack while idle.
    mem_ack = 1;
    tick(); tick();
    check("t6_spur_c_ack", {31'd0, c_ack}, 32'd0);
    check("t6_spur_k_ack", {31'd0, k_ack}, 32'd0);
    check("t6_spur_mem_req", {31'd0, mem_req}, 32'd0);
    mem_ack = 0;

    // Timeout instance: memory never acks.
    rst = 1; rst_t = 0;
    tick();
    c_req = 1; c_wr = 0; c_addr = 32'h40;
    tick();
    for (int i = 0; i < 4; i++) begin
      check("t4_mem_req_high", {31'd0, t_mem_req}, 32'd1);
      check("t4_no_ack_yet", {31'd0, t_c_ack}, 32'd0);
      tick();
    end
    check("t4_mem_req_low", {31'd0, t_mem_req}, 32'd0);
    check("t4_c_ack", {31'd0, t_c_ack}, 32'd1);
    check("t4_c_err", {31'd0, t_c_err}, 32'd1);
    check("t4_c_rd_data", t_c_rd_data, 32'd0);
    c_req = 0;
    tick();
    check("t4_ack_pulse", {31'd0, t_c_ack}, 32'd0);

    // Next request proceeds normally.
    c_req = 1;
    tick();
    mem_ack_t = 1; mem_rd_data = 32'h55AA;
    tick();
    check("t4_next_ack", {31'd0, t_c_ack}, 32'd1);
    check("t4_next_err", {31'd0, t_c_err}, 32'd0);
    check("t4_next_rd", t_c_rd_data, 32'h55AA);
    mem_ack_t = 0;
    tick();

    // mem_ack arriving in the timeout cycle completes normally.
    tick();
    check("t6_busy", {31'd0, t_mem_req}, 32'd1);
    mem_rd_data = 32'h0BADF00D;
    tick(); tick(); tick();
    check("t6_still_busy", {31'd0, t_mem_req}, 32'd1);
    mem_ack_t = 1;
    tick();
    check("t6_edge_ack", {31'd0, t_c_ack}, 32'd1);
    check("t6_edge_err", {31'd0, t_c_err}, 32'd0);
    check("t6_edge_rd", t_c_rd_data, 32'h0BADF00D);
    mem_ack_t = 0; c_req = 0;
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gpu_mem_arbiter.md
Name: gpu_mem_arbiter

Overview:
- Sits directly downstream of gpu_controller's memory port; shares the single GPU memory between the controller and the core.
- Accepts word read/write requests on two requester ports: port 0 = controller, port 1 = core.
- Grants one request at a time, round-robin, and forwards it to memory with a req/ack handshake.
- Returns read data and ack to the winner; a timeout returns an error on a hung memory.

Parameters:
- addr_width, 32, address width in bits (byte address, forwarded unchanged).
- data_width, 32, data word width.
- TIMEOUT_CYCLES, 64, maximum cycles waiting for mem_ack; 0 disables the timeout.

Ports:
- clk  input  1  clock; all state changes on posedge.
- rst  input  1  reset, asynchronous and active-high.
- c_req  input  1  controller request; held until c_ack.
- c_wr  input  1  controller: 1 = write, 0 = read.
- c_addr  input  addr_width  controller address.
- c_wr_data  input  data_width  controller write data.
- c_ack  output  1  one-cycle completion pulse to controller.
- c_err  output  1  valid with c_ack; 1 = timed out.
- c_rd_data  output  data_width  read data, valid with c_ack.
- k_req, k_wr, k_addr, k_wr_data, k_ack, k_err, k_rd_data  same as c_* for the core port.
- mem_req  output  1  request to memory.
- mem_wr  output  1  write enable to memory.
- mem_addr  output  addr_width  memory address.
- mem_wr_data  output  data_width  memory write data.
- mem_ack  input  1  memory completion, one cycle.
- mem_rd_data  input  data_width  memory read data, valid with mem_ack.

Behaviour:
- All outputs registered.
- rst high (any time, including mid-transaction):
  - all outputs 0; state IDLE; timeout counter 0.
  - last_grant = 1, so port 0 wins the first contention.
  - any in-flight memory transaction is abandoned; no ack is issued for it.
- States: IDLE, BUSY, RESP.
- IDLE:
  - Samples c_req/k_req.
  - Only one asserted: grant it. Both asserted: grant the port != last_grant.
  - On grant: next cycle mem_req = 1; mem_wr/mem_addr/mem_wr_data latched from the winner; last_grant = winner; counter = 0; go BUSY.
  - No request: stay IDLE.
- BUSY:
  - mem_req and the latched fields held stable; requester inputs ignored.
  - mem_ack = 1: next cycle mem_req = 0; winner's ack = 1, err = 0; winner's rd_data = mem_rd_data if read, else 0; go RESP.
  - Otherwise counter increments. If TIMEOUT_CYCLES != 0 and counter reaches TIMEOUT_CYCLES-1 with no mem_ack: next cycle mem_req = 0; winner's ack = 1, err = 1, rd_data = 0; go RESP.
  - mem_ack in the timeout cycle takes precedence: normal completion.
- RESP:
  - ack/err/rd_data high or valid for exactly this cycle; both req inputs ignored.
  - Next cycle: ack/err = 0, go IDLE.
  - rd_data holds its value until the next completion on that port.
- Requester rule: on the edge where it samples ack = 1, the requester either drops req or presents the next transaction. IDLE then samples the updated req, so no double grant.
- Latency: req sampled at cycle 0 → mem_req at cycle 1 → mem_ack earliest cycle 1 → ack at cycle 2 → IDLE at cycle 3. Minimum 3 cycles per transaction.
- Fairness: with both ports continuously requesting, grants strictly alternate.
- mem_ack while not BUSY: ignored (no ack, no state change).
- Non-granted port's ack/err/rd_data: unaffected.
- Counter width: $clog2(TIMEOUT_CYCLES+1), minimum 1 bit. Counter saturates and never wraps.

Test Plan:
- Reset, then c_req read addr 0x10; memory acks in mem_req's first cycle with 0xDEADBEEF → mem_req at cycle 1, c_ack = 1 with c_rd_data = 0xDEADBEEF and c_err = 0 at cycle 2, k_ack stays 0.
- k_req write addr 0x20 data 0x1234; memory acks after 5 cycles → mem_wr = 1, mem_addr = 0x20, mem_wr_data = 0x1234 stable for all 5 BUSY cycles; k_ack = 1 with k_rd_data = 0.
- c_req and k_req both held high for 4 transactions → grant order 0,1,0,1; each ack is a single-cycle pulse.
- TIMEOUT_CYCLES = 4, memory never acks → mem_req high exactly 4 cycles; then c_ack = 1, c_err = 1, c_rd_data = 0; next request proceeds normally.
- rst asserted during BUSY → mem_req drops immediately (async); no c_ack/k_ack; after release both pending requests → port 0 granted first.
- Spurious mem_ack in IDLE, and mem_ack coinciding with the timeout cycle → no ack for the first; normal ack with err = 0 for the second.
